// File: rtl/sb_reg_pkg.sv
// Shared types and constants for the sideband register file.
// Reset image of the link configuration and read-only window lives here.
package sb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } sb_state_e;

    localparam logic [7:0] SB_RST_78 = 8'h03;
    localparam logic [7:0] SB_RST_79 = 8'h33;
    localparam logic [7:0] SB_RST_80 = 8'h05;
    localparam logic [7:0] SB_RST_87 = 8'hC0;
    localparam logic [7:0] SB_RST_88 = 8'hC0;

    localparam int SB_LINK_CFG_ADDR = 78;
    localparam int SB_RO_BASE       = 85;
    localparam int SB_RO_COUNT      = 4;

endpackage

// File: rtl/sb_register_file.sv
// Sideband register file: one byte per cycle, response len+1 cycles after accept (1 for illegal len).
// req_ready is high only while idle; no request is taken while a transaction is in flight.
module sb_register_file
    import sb_reg_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DEPTH         = 157,
    parameter int MAX_LEN       = 4,
    parameter int LEN_W         = 3,
    parameter int LINK_CFG_ADDR = SB_LINK_CFG_ADDR,
    parameter int RO_BASE       = SB_RO_BASE,
    parameter int RO_COUNT      = SB_RO_COUNT
) (
    input  logic                   fsm_clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [LEN_W-1:0]       req_len,
    input  logic [8*MAX_LEN-1:0]   req_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [8*MAX_LEN-1:0]   rsp_rdata,
    output logic [23:0]            link_configuration
);

    localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  RO_LO     = (ADDR_W+1)'(RO_BASE);
    localparam logic [ADDR_W:0]  RO_HI     = (ADDR_W+1)'(RO_BASE + RO_COUNT);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    sb_state_e            state;
    logic [7:0]           mem [DEPTH];
    logic [ADDR_W-1:0]    addr_q;
    logic [LEN_W-1:0]     len_q;
    logic                 write_q;
    logic [8*MAX_LEN-1:0] wdata_q;
    logic [LEN_W-1:0]     idx;
    logic                 err_q;
    logic [8*MAX_LEN-1:0] rdata_acc;

    logic [ADDR_W:0]      cur_addr;
    logic                 cur_in_range;
    logic                 cur_ro;
    logic                 len_ok;

    // One extra address bit so a burst running past the top never wraps to 0.
    assign cur_addr     = {1'b0, addr_q} + (ADDR_W+1)'(idx);
    assign cur_in_range = cur_addr < DEPTH_L;
    assign cur_ro       = (cur_addr >= RO_LO) && (cur_addr < RO_HI);
    assign len_ok       = (req_len != '0) && (req_len <= MAX_LEN_L);
    assign req_ready    = (state == IDLE);

    assign link_configuration = {mem[LINK_CFG_ADDR+2], mem[LINK_CFG_ADDR+1], mem[LINK_CFG_ADDR]};

    always_ff @(posedge fsm_clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            idx       <= '0;
            err_q     <= 1'b0;
            rdata_acc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            mem[LINK_CFG_ADDR]   <= SB_RST_78;
            mem[LINK_CFG_ADDR+1] <= SB_RST_79;
            mem[LINK_CFG_ADDR+2] <= SB_RST_80;
            mem[RO_BASE+2]       <= SB_RST_87;
            mem[RO_BASE+3]       <= SB_RST_88;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        len_q     <= req_len;
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        idx       <= '0;
                        rdata_acc <= '0;
                        err_q     <= !len_ok;
                        state     <= len_ok ? ACCESS : RESP;
                    end
                end
                ACCESS: begin
                    // Faulty bytes only raise err; the rest of the burst still runs.
                    if (write_q) begin
                        if (cur_in_range && !cur_ro) begin
                            mem[cur_addr[ADDR_W-1:0]] <= wdata_q[8*idx +: 8];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        if (cur_in_range) begin
                            rdata_acc[8*idx +: 8] <= mem[cur_addr[ADDR_W-1:0]];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    idx <= idx + 1'b1;
                    if (idx == len_q - 1'b1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= rdata_acc;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sb_register_file.md
Name: sb_register_file

Overview:
- Parametrised sideband register file for the USB4 logical layer, the successor of the fixed 157-byte sideband register store.
- Serves multi-byte read/write transactions over a valid/ready request port and returns one response per request.
- Enforces a read-only window and out-of-range checks.
- Continuously exports the 24-bit link configuration (bytes 78..80) to the link/lane FSMs.

Parameters:
- ADDR_W, 8, register address width in bits.
- DEPTH, 157, number of 8-bit registers; legal addresses are 0..DEPTH-1.
- MAX_LEN, 4, maximum bytes per transaction.
- LEN_W, 3, width of req_len; must satisfy 2^LEN_W > MAX_LEN.
- LINK_CFG_ADDR, 78, base address of the 3-byte link configuration.
- RO_BASE, 85, first read-only register.
- RO_COUNT, 4, number of read-only registers (85..88 by default).

Ports:
- fsm_clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  byte count, legal range 1..MAX_LEN.
- req_wdata  in  8*MAX_LEN  write bytes; byte i sits in bits [8i+7:8i].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- rsp_rdata  out  8*MAX_LEN  read bytes, little-endian by byte.
- link_configuration  out  24  {mem[LINK_CFG_ADDR+2], mem[LINK_CFG_ADDR+1], mem[LINK_CFG_ADDR]}.

Behaviour:
- Reset (rst high at a fsm_clk edge):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0.
  - mem[78] = 0x03, mem[79] = 0x33, mem[80] = 0x05, mem[87] = 0xC0, mem[88] = 0xC0; all other bytes 0.
  - link_configuration = 0x053303 in the first cycle after reset.
  - Reset mid-transaction aborts it: no response is issued, and bytes already written are overwritten by reset values.
- Accept: req_valid && req_ready at edge T. Address, len, write flag and wdata are captured into internal registers; req_inputs are ignored afterwards.
- FSM states:
  - IDLE: waits for accept. If len is legal go to ACCESS with byte counter idx = 0; otherwise go to RESP with err = 1.
  - ACCESS: processes one byte per cycle at address a = addr + idx (computed at ADDR_W+1 bits, so there is no wrap-around).
    - Read: rdata byte idx = mem[a] if a < DEPTH, else 0 with err set.
    - Write: mem[a] = wdata byte idx if a < DEPTH and a is outside [RO_BASE, RO_BASE+RO_COUNT). Otherwise the byte is dropped and err is set. Remaining bytes are still processed.
    - idx increments each cycle; after idx = len-1, go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle with the accumulated err and rdata, then go to IDLE.
- Latency: accept at T gives rsp_valid at edge T+len+1; an illegal len gives rsp_valid at T+1. Back-to-back throughput is one request per len+2 cycles.
- rsp_rdata:
  - Unused upper bytes are 0; writes return rsp_rdata = 0.
  - rsp_rdata and rsp_err hold their values after the pulse until the next RESP.
  - The rdata accumulator clears on accept.
- A read of a byte returns its value as it stands at that cycle. There is no same-transaction hazard, because each byte is touched once.
- link_configuration is combinational from mem and reflects a write one cycle after the byte's ACCESS edge.
- A write touching the link configuration bytes updates each byte independently. Partial updates are visible between bytes.

Decomposition:
- Package sb_reg_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - reset-value constants (SB_RST_78 = 8'h03, SB_RST_79 = 8'h33, SB_RST_80 = 8'h05, SB_RST_87 = 8'hC0, SB_RST_88 = 8'hC0);
  - address constants LINK_CFG_ADDR, RO_BASE, RO_COUNT.
- No sub-module: FSM, counter and array fit in one module of roughly 200 lines.

Test Plan:
- Reset then read addr 78, len 3 -> rsp_valid 4 cycles after accept; rsp_rdata = 0x00053303; rsp_err = 0; link_configuration = 0x053303.
- Write addr 78, len 2, wdata 0x00000A07, then read addr 78, len 3 -> rsp_rdata = 0x00050A07; link_configuration = 0x050A07; both rsp_err = 0.
- Write addr 84, len 4, wdata 0x44332211 -> mem[84] = 0x11; bytes 85..87 unchanged (mem[87] still 0xC0); rsp_err = 1 at T+5.
- Read addr 155, len 4 (DEPTH 157) -> rsp_rdata = {0, 0, mem[156], mem[155]}; rsp_err = 1.
- req_len = 0 and req_len = 5 -> rsp_valid at T+1 with rsp_err = 1; memory unchanged; req_ready low for exactly 1 cycle.
- rst asserted in the second ACCESS cycle of a 4-byte write -> no rsp_valid; req_ready = 1 the next cycle; all bytes back at reset values.
